// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: drives shifter load/shift strobes, sclk, cs_n
// and captures 8 miso bits into rx_data with a one-cycle done pulse.
// Ports: clk, rst (sync, active-low), start, tx_data, tx_bit, miso ->
//   busy, done, rx_data, shd_data, load, shift_en, sclk, cs_n.
// Option: define SPI_LOOPBACK_EN to sample tx_bit instead of miso.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       tx_bit,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic [7:0] shd_data,
  output logic       load,
  output logic       shift_en,
  output logic       sclk,
  output logic       cs_n
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, LOW, HIGH, DONE
  } state_t;

  state_t          state, nxt;
  logic [2:0]      bit_cnt;
  logic [DW-1:0]   div_cnt;
  logic [7:0]      rx_sr;
  logic            last;
  logic            sin;
  logic            unused;
  logic            busy_d, done_d, load_d;
  logic            shift_d, sclk_d, cs_n_d;

`ifdef SPI_LOOPBACK_EN
  assign sin    = tx_bit;
  assign unused = miso;
`else
  assign sin    = miso;
  assign unused = tx_bit;
`endif

  assign last = (div_cnt == DLAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: nxt = LOW;
      LOW:  if (last) nxt = HIGH;
      HIGH: if (last) nxt = (bit_cnt == 3'd7) ? DONE : LOW;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered
  // copies line up with the state they belong to.
  always_comb begin
    load_d  = (nxt == LOAD);
    sclk_d  = (nxt == HIGH);
    done_d  = (nxt == DONE);
    busy_d  = (nxt != IDLE);
    cs_n_d  = (nxt == IDLE) || (nxt == DONE);
    shift_d = (state == HIGH) && last && (bit_cnt != 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      load     <= 1'b0;
      shift_en <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      rx_data  <= '0;
      shd_data <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      load     <= load_d;
      shift_en <= shift_d;
      sclk     <= sclk_d;
      cs_n     <= cs_n_d;
      if (state == IDLE && start) begin
        shd_data <= tx_data;
        bit_cnt  <= '0;
      end
      if (state == LOW || state == HIGH)
        div_cnt <= last ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;
      // Sample on the rising sclk edge.
      if (state == LOW && last)
        rx_sr <= {rx_sr[6:0], sin};
      if (shift_d)
        bit_cnt <= bit_cnt + 3'd1;
      if (state == HIGH && last && bit_cnt == 3'd7)
        rx_data <= rx_sr;
    end
  end

endmodule
